// File: rtl/vga_text_renderer.sv
// vga_text_renderer: scans a 64x48 grid of 10x10-pixel character cells and
// produces 640x480@60 Hz VGA timing. Character/colour bytes come from the
// MMIO text buffer (indexed by vga_addr), glyph rows from an external
// synchronous font ROM. Everything past the clock divider moves one step per
// pixel tick, with a two-tick pipeline from counter to RGB/sync outputs.
module vga_text_renderer #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] vga_addr,
  input  logic [7:0]  char_in,
  input  logic [7:0]  color_in,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_r;
  logic          tick_s;

  // stage 0: raster position and cell sub-counters
  logic [9:0] hcnt_r, vcnt_r, hcnt_s, vcnt_s;
  logic [3:0] hcell_r, vcell_r, hcell_s, vcell_s;
  logic [5:0] col_r, row_r, col_s, row_s;

  // stage 1: captured cell context
  logic [7:0] color1_r;
  logic [3:0] hcell1_r, vcell1_r;
  logic       active1_r, hs1_r, vs1_r;
  logic [2:0] glyph_row_s;

  // stage 2: pixel decision
  logic [2:0] bit_idx_s;
  logic       pix_on_s;

  assign tick_s = (div_r == DIV_LAST);

  // pixel tick divider: free-running 0..CLK_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // next raster position; cell counters stay at 0 outside the visible area
  always_comb begin
    hcnt_s  = hcnt_r;
    vcnt_s  = vcnt_r;
    hcell_s = hcell_r;
    col_s   = col_r;
    vcell_s = vcell_r;
    row_s   = row_r;
    if (hcnt_r == H_LAST) begin
      hcnt_s  = 10'd0;
      hcell_s = 4'd0;
      col_s   = 6'd0;
      if (vcnt_r == V_LAST) begin
        vcnt_s  = 10'd0;
        vcell_s = 4'd0;
        row_s   = 6'd0;
      end else begin
        vcnt_s = vcnt_r + 10'd1;
        if (vcnt_r < V_VIS_LAST) begin
          if (vcell_r == 4'd9) begin
            vcell_s = 4'd0;
            row_s   = row_r + 6'd1;
          end else begin
            vcell_s = vcell_r + 4'd1;
          end
        end else begin
          vcell_s = 4'd0;
          row_s   = 6'd0;
        end
      end
    end else begin
      hcnt_s = hcnt_r + 10'd1;
      if (hcnt_r < H_VIS_LAST) begin
        if (hcell_r == 4'd9) begin
          hcell_s = 4'd0;
          col_s   = col_r + 6'd1;
        end else begin
          hcell_s = hcell_r + 4'd1;
        end
      end else begin
        hcell_s = 4'd0;
        col_s   = 6'd0;
      end
    end
  end

  // stage 0 registers: counters and the MMIO cell address move together
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_r   <= 10'd0;
      vcnt_r   <= 10'd0;
      hcell_r  <= 4'd0;
      vcell_r  <= 4'd0;
      col_r    <= 6'd0;
      row_r    <= 6'd0;
      vga_addr <= 12'd0;
    end else if (tick_s) begin
      hcnt_r   <= hcnt_s;
      vcnt_r   <= vcnt_s;
      hcell_r  <= hcell_s;
      vcell_r  <= vcell_s;
      col_r    <= col_s;
      row_r    <= row_s;
      vga_addr <= {row_s, col_s};
    end else begin
      vga_addr <= vga_addr;
    end
  end

  // glyph row inside the cell; margin lines fetch row 0 and are masked later
  always_comb begin
    glyph_row_s = 3'd0;
    if ((vcell_r >= 4'd1) && (vcell_r <= 4'd8)) begin
      glyph_row_s = 3'(vcell_r - 4'd1);
    end else begin
      glyph_row_s = 3'd0;
    end
  end

  // stage 1: latch cell context and issue the font ROM read
  always_ff @(posedge clk) begin
    if (reset) begin
      color1_r  <= 8'd0;
      hcell1_r  <= 4'd0;
      vcell1_r  <= 4'd0;
      active1_r <= 1'b0;
      hs1_r     <= 1'b0;
      vs1_r     <= 1'b0;
      font_addr <= 11'd0;
    end else if (tick_s) begin
      color1_r  <= color_in;
      hcell1_r  <= hcell_r;
      vcell1_r  <= vcell_r;
      active1_r <= (hcnt_r < H_VIS_W) && (vcnt_r < V_VIS_W);
      hs1_r     <= (hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST);
      vs1_r     <= (vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST);
      font_addr <= {char_in, glyph_row_s};
    end else begin
      font_addr <= font_addr;
    end
  end

  // bit 7 of a glyph row is the leftmost pixel (hcell 1)
  assign bit_idx_s = 3'(4'd8 - hcell1_r);

  // foreground pixel only inside the 8x8 glyph of a visible cell
  always_comb begin
    pix_on_s = 1'b0;
    if (active1_r && (hcell1_r >= 4'd1) && (hcell1_r <= 4'd8) &&
        (vcell1_r >= 4'd1) && (vcell1_r <= 4'd8)) begin
      pix_on_s = font_data[bit_idx_s];
    end else begin
      pix_on_s = 1'b0;
    end
  end

  // stage 2: colour expansion and sync outputs, aligned with the pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick_s) begin
      red   <= pix_on_s ? {color1_r[7:5], color1_r[7]} : 4'd0;
      green <= pix_on_s ? {color1_r[4:2], color1_r[4]} : 4'd0;
      blue  <= pix_on_s ? {color1_r[1:0], color1_r[1:0]} : 4'd0;
      hsync <= ~hs1_r;
      vsync <= ~vs1_r;
    end else begin
      hsync <= hsync;
      vsync <= vsync;
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Testbench for vga_text_renderer. Instance A uses the full 640x480 timing and
// is checked over the first lines; instance B uses a shrunken raster so whole
// frames (sync pulse counts, last cell, frame wrap) fit in a short run.
module tb_vga_text_renderer;

  typedef struct {
    int div;
    int hv, hfp, hsw, hbp;
    int vv, vfp, vsw, vbp;
  } geom_t;

  typedef struct {
    logic [7:0] color;
    logic [3:0] r, g, b;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  logic [11:0] vga_addr_a, vga_addr_b;
  logic [7:0]  char_a, char_b, color_a, color_b, font_data_a, font_data_b;
  logic [10:0] font_addr_a, font_addr_b;
  logic        hsync_a, vsync_a, hsync_b, vsync_b;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

  logic [7:0] char_mem  [0:4095];
  logic [7:0] color_mem [0:4095];
  logic [7:0] font_rom  [0:2047];
  logic [13:0] cap [0:6999];

  geom_t ga, gb;
  vec_t vt [7];
  int n_cmp = 0;
  int n_bad = 0;
  int tick_n [2];
  int hs_low, hs_fall, vs_low, vs_fall;
  logic prev_hs, prev_vs;

  assign char_a  = char_mem[vga_addr_a];
  assign color_a = color_mem[vga_addr_a];
  assign char_b  = char_mem[vga_addr_b];
  assign color_b = color_mem[vga_addr_b];

  // synchronous font ROM: data one clk after address
  always @(posedge clk) begin
    font_data_a <= font_rom[font_addr_a];
    font_data_b <= font_rom[font_addr_b];
  end

  vga_text_renderer dut_a (
    .clk(clk), .reset(reset_a), .vga_addr(vga_addr_a), .char_in(char_a),
    .color_in(color_a), .font_addr(font_addr_a), .font_data(font_data_a),
    .hsync(hsync_a), .vsync(vsync_a), .red(red_a), .green(green_a), .blue(blue_a)
  );

  vga_text_renderer #(
    .CLK_DIV(2), .H_VIS(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .vga_addr(vga_addr_b), .char_in(char_b),
    .color_in(color_b), .font_addr(font_addr_b), .font_data(font_data_b),
    .hsync(hsync_b), .vsync(vsync_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  // expected {hsync, vsync, red, green, blue} for raster position p (p<0: reset)
  function automatic logic [13:0] ref_out(input geom_t g, input int p);
    int htot, vtot, q, x, y, cx, cy, ch, bits, c;
    logic hs, vs;
    logic [3:0] r, gg, b;
    if (p < 0) return {1'b1, 1'b1, 12'h000};
    htot = g.hv + g.hfp + g.hsw + g.hbp;
    vtot = g.vv + g.vfp + g.vsw + g.vbp;
    q = p % (htot * vtot);
    x = q % htot;
    y = q / htot;
    hs = !(x >= g.hv + g.hfp && x < g.hv + g.hfp + g.hsw);
    vs = !(y >= g.vv + g.vfp && y < g.vv + g.vfp + g.vsw);
    r = 4'd0; gg = 4'd0; b = 4'd0;
    cx = x % 10;
    cy = y % 10;
    if (x < g.hv && y < g.vv && cx >= 1 && cx <= 8 && cy >= 1 && cy <= 8) begin
      ch = char_mem[(y / 10) * 64 + x / 10];
      bits = font_rom[ch * 8 + cy - 1];
      if (((bits >> (8 - cx)) & 1) == 1) begin
        c = color_mem[(y / 10) * 64 + x / 10];
        r  = 4'((((c >> 5) & 7) * 15 + 3) / 7);
        gg = 4'((((c >> 2) & 7) * 15 + 3) / 7);
        b  = 4'((c & 3) * 5);
      end
    end
    return {hs, vs, r, gg, b};
  endfunction

  function automatic int ref_addr(input geom_t g, input int p);
    int htot, vtot, q, x, y;
    if (p < 0) return 0;
    htot = g.hv + g.hfp + g.hsw + g.hbp;
    vtot = g.vv + g.vfp + g.vsw + g.vbp;
    q = p % (htot * vtot);
    x = q % htot;
    y = q / htot;
    return ((y < g.vv) ? y / 10 : 0) * 64 + ((x < g.hv) ? x / 10 : 0);
  endfunction

  function automatic int ref_font(input geom_t g, input int p);
    int htot, vtot, y, cy;
    if (p < 0) return 0;
    htot = g.hv + g.hfp + g.hsw + g.hbp;
    vtot = g.vv + g.vfp + g.vsw + g.vbp;
    y = (p % (htot * vtot)) / htot;
    cy = (y < g.vv) ? y % 10 : 0;
    return char_mem[ref_addr(g, p)] * 8 + ((cy >= 1 && cy <= 8) ? cy - 1 : 0);
  endfunction

  task automatic cmp(input string name, input int n, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at tick %0d: got %0h, expected %0h", name, n, got, exp);
    end
  endtask

  // compare one instance against the model after its n-th tick
  task automatic check_tick(input int inst, input int n);
    geom_t g;
    logic [13:0] pix;
    int addr, fa;
    if (inst == 0) begin
      g = ga; pix = {hsync_a, vsync_a, red_a, green_a, blue_a};
      addr = vga_addr_a; fa = font_addr_a;
      if (n >= 2 && n - 2 < 7000) cap[n - 2] = pix;
    end else begin
      g = gb; pix = {hsync_b, vsync_b, red_b, green_b, blue_b};
      addr = vga_addr_b; fa = font_addr_b;
    end
    cmp(inst == 0 ? "pixel_a" : "pixel_b", n, pix, ref_out(g, n - 2));
    cmp(inst == 0 ? "vga_addr_a" : "vga_addr_b", n, addr, ref_addr(g, n));
    cmp(inst == 0 ? "font_addr_a" : "font_addr_b", n, fa, ref_font(g, n - 1));
  endtask

  // advance an instance tick by tick up to tick number last_n
  task automatic run_ticks(input int inst, input int last_n);
    int div;
    div = (inst == 0) ? ga.div : gb.div;
    while (tick_n[inst] < last_n) begin
      tick_n[inst]++;
      repeat (div) @(negedge clk);
      check_tick(inst, tick_n[inst]);
      if (inst == 1 && tick_n[1] >= 2 && tick_n[1] <= 1729) begin
        if (!hsync_b) hs_low++;
        if (!vsync_b) vs_low++;
        if (prev_hs && !hsync_b) hs_fall++;
        if (prev_vs && !vsync_b) vs_fall++;
        prev_hs = hsync_b;
        prev_vs = vsync_b;
      end
    end
  endtask

  initial begin
    ga = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    gb = '{2, 40, 2, 4, 2, 30, 2, 2, 2};
    vt[0] = '{8'b01001001, 4'h4, 4'h4, 4'h5};
    vt[1] = '{8'hE0, 4'hF, 4'h0, 4'h0};
    vt[2] = '{8'h1C, 4'h0, 4'hF, 4'h0};
    vt[3] = '{8'h03, 4'h0, 4'h0, 4'hF};
    vt[4] = '{8'hFF, 4'hF, 4'hF, 4'hF};
    vt[5] = '{8'h00, 4'h0, 4'h0, 4'h0};
    vt[6] = '{8'b10110110, 4'hB, 4'hB, 4'hA};

    for (int i = 0; i < 4096; i++) begin
      char_mem[i]  = 8'($urandom);
      color_mem[i] = 8'($urandom);
    end
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    for (int r = 0; r < 8; r++) begin
      font_rom[8'h41 * 8 + r] = 8'h80;
      font_rom[8 + r] = 8'hFF;
    end
    char_mem[0] = 8'h41;
    color_mem[0] = 8'hE0;
    for (int i = 0; i < 7; i++) begin
      char_mem[i + 1]  = 8'h01;
      color_mem[i + 1] = vt[i].color;
    end
    char_mem[131] = 8'h01;  color_mem[131] = 8'hFF;
    char_mem[3071] = 8'h01; color_mem[3071] = 8'hFF;

    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (5) @(negedge clk);
    check_tick(0, 0);
    check_tick(1, 0);

    // instance A: first lines at full timing, then a mid-line reset at hcnt=300
    reset_a = 1'b0;
    tick_n[0] = 0;
    run_ticks(0, 6700);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    check_tick(0, 0);
    tick_n[0] = 0;
    run_ticks(0, 12);

    // colour expansion table: centre of glyph cells 1..7 on pixel row 3
    for (int i = 0; i < 7; i++) begin
      cmp($sformatf("color_vec%0d", i), 3 * 800 + (i + 1) * 10 + 4,
          cap[3 * 800 + (i + 1) * 10 + 4][11:0], {vt[i].r, vt[i].g, vt[i].b});
    end

    // cell 0 ('A' with a single left column): only x=1, y=1..8 lit red
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 10; x++) begin
        cmp($sformatf("cell0_x%0d_y%0d", x, y), y * 800 + x, cap[y * 800 + x][11:0],
            (x == 1 && y >= 1 && y <= 8) ? 12'hF00 : 12'h000);
      end
    end

    // instance B: two full frames with sync statistics, then mid-frame reset
    reset_a = 1'b1;
    hs_low = 0; hs_fall = 0; vs_low = 0; vs_fall = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
    reset_b = 1'b0;
    tick_n[1] = 0;
    run_ticks(1, 2 * 1728 + 2);
    cmp("hsync_low_ticks", tick_n[1], hs_low, 36 * 4);
    cmp("hsync_pulses", tick_n[1], hs_fall, 36);
    cmp("vsync_low_ticks", tick_n[1], vs_low, 2 * 48);
    cmp("vsync_pulses", tick_n[1], vs_fall, 1);
    run_ticks(1, 2 * 1728 + 20 * 48 + 30);
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    check_tick(1, 0);
    tick_n[1] = 0;
    run_ticks(1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Consumes the character and colour bytes exposed by the MMIO VGA text buffer and produces 640x480@60 Hz VGA output.
- Scans a 64-column x 48-row character grid with 10x10-pixel cells. Each cell holds an 8x8 glyph with a 1-pixel margin on every side.
- Drives VgaAddress into the MMIO block and the glyph address into an external synchronous font ROM.
- Pixel pipeline advances only on a pixel tick derived from clk.

Parameters:
- CLK_DIV, 4, clk cycles per pixel tick (100 MHz / 4 = 25 MHz); legal values >= 2.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vga_addr  out  12  character cell index {row[5:0], col[5:0]}; connects to MMIO VgaAddress
- char_in  in  8  character code from MMIO CharOut (combinational on vga_addr)
- color_in  in  8  foreground colour from MMIO ColorOut, format RRRGGGBB
- font_addr  out  11  {char[7:0], glyph_row[2:0]} to font ROM
- font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 clk after font_addr
- hsync  out  1  active-low
- vsync  out  1  active-low
- red  out  4  pixel red
- green  out  4  pixel green
- blue  out  4  pixel blue

Behaviour:
- Tick divider: a counter runs 0..CLK_DIV-1 and tick=1 when it equals CLK_DIV-1. All state below updates only on cycles where tick=1.
- Stage 0, counters:
  - hcnt runs 0..799 and vcnt runs 0..524.
  - hcnt wraps to 0 at 799; vcnt increments on that wrap and itself wraps at 524.
  - Sub-counters hcell 0..9 and col 0..63 advance with hcnt inside the visible region and reset to 0 when hcnt wraps.
  - vcell 0..9 and row 0..47 advance with each line inside the visible region and reset to 0 when vcnt wraps.
  - No divider is used anywhere.
- vga_addr = {row, col}, registered with the counters. Maximum value is 3071.
- Stage 1, on tick:
  - Capture char_in and color_in.
  - Capture hcell, vcell, active = (hcnt<640 && vcnt<480), hs0 = (hcnt in [656,751]), vs0 = (vcnt in [490,491]).
  - font_addr <= {char_in, vcell-1} when vcell in 1..8; otherwise font_addr <= {char_in, 3'd0}.
- Stage 2, on tick:
  - on = active && hcell in 1..8 && vcell in 1..8 && font_data[8-hcell].
  - red <= on ? {R3, R3[2]} : 0
  - green <= on ? {G3, G3[2]} : 0
  - blue <= on ? {B2, B2} : 0
  - hsync <= ~hs0 and vsync <= ~vs0, so sync stays aligned with the pixel data.
  - font_data is sampled at least CLK_DIV-1 >= 1 clk after font_addr changed, so ROM latency is met.
- Latency: 2 ticks from counter value to the RGB/sync outputs.
- Background is always black. Blanking regions output RGB=0.
- Reset:
  - Divider, hcnt, vcnt, sub-counters, vga_addr and font_addr clear to 0.
  - All stage registers clear; hsync=1, vsync=1, red/green/blue=0.
  - Reset mid-frame restarts at pixel (0,0) on the first tick after reset deasserts, with no partial-line artefacts.
- Writes into MMIO during scan are not synchronised. New contents appear the next time the cell is scanned (tearing is acceptable).

Test Plan:
- Reset held 5 clk, then released -> hsync=1, vsync=1, RGB=0 until the pipeline fills; first tick gives hcnt=1 and vga_addr=0.
- Free run 800*525*4 clk -> exactly 1 vsync pulse of 2 lines and 525 hsync pulses of 96 ticks each; hsync falls 2 ticks after hcnt=656.
- MMIO model with char[0]=8'h41 and color[0]=8'hE0, font model returning 8'h80 for every row -> pixels x=1, y=1..8 are red=4'hF, green=0, blue=0; x=0 and x=2..9 are black.
- char[3071]=8'h01 and color[3071]=8'hFF -> vga_addr reaches 3071 at hcnt=630 and vcnt=470; white pixels appear only inside x 631..638, y 471..478.
- color_in=8'b01001001 -> red=4'h4 (010 -> 0100), green=4'h4, blue=4'h5 (01 -> 0101).
- Reset asserted at hcnt=300, vcnt=200 for 1 clk -> next ticks restart at (0,0); outputs are 0/1/1 for the 2 pipeline ticks after reset.
